booth_mult_r4_hs: RTL and testbench
===================================

# booth_mult_r4_hs

Parametrised, iterative radix-4 Booth multiplier with per-operation signed/unsigned mode and valid/ready handshakes on both input and output. It processes one Booth digit per cycle. Result is held until the consumer accepts it, so the block drops straight into streaming datapaths. It supersedes the fixed-load Booth multiplier as the shared multiply unit for narrow fixed-point paths.

## Interface
- A_WIDTH, 6, multiplicand width; must be ≥ 2
- B_WIDTH, 6, multiplier width; must be ≥ 2; odd values allowed
- P_WIDTH, A_WIDTH+B_WIDTH, product width; must equal A_WIDTH+B_WIDTH
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands A, B, in_signed valid
- in_ready  out  1  block can accept operands
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned
- A  in  A_WIDTH  multiplicand
- B  in  B_WIDTH  multiplier
- out_valid  out  1  P holds a completed product
- out_ready  in  1  consumer accepts P
- P  out  P_WIDTH  product
- busy  out  1  high in CALC or DONE

## Operation
- ITER = (B_WIDTH+2)/2 (integer division); BX = 2*ITER.
- On accept (in_valid && in_ready at an edge), the block latches its inputs:
  - A is extended to A_WIDTH+1 bits: sign-extended if in_signed, else zero-extended.
  - B is extended to BX bits the same way, with overlap bit b[-1] = 0.
  - Accumulator and digit counter k are cleared; state → CALC.
- States: IDLE → CALC → DONE → IDLE.
- CALC: each edge consumes the triplet {b[2k+1], b[2k], b[2k-1]}.
  - Digit d ∈ {0, ±1, ±2}. Accumulator += d·A·4^k.
  - Accumulator is P_WIDTH+2 bits wide internally. k++.
  - When k reaches ITER → DONE.
- DONE: out_valid = 1; P = low P_WIDTH bits of the accumulator, equal to the exact product in both modes.
  - P and out_valid stay stable until out_ready.
  - out_valid && out_ready at an edge → IDLE, out_valid = 0.
- in_ready = (state == IDLE) && !rst. No accept is possible in CALC or DONE.
- in_valid while in CALC or DONE is ignored; the source must hold it.
- Inputs A, B and in_signed are sampled only at accept and may change freely afterward.
- Reset at any time, including mid-CALC or in DONE:
  - Next edge: state = IDLE, out_valid = 0, P = 0, k = 0, busy = 0.
  - The in-flight operation is discarded and no out_valid is ever produced for it.
- Reset values: in_ready 0 while rst is high, 1 in the first cycle after; out_valid 0; P 0; busy 0.

## Timing
- Accept edge E0. Digit edges E1..E_ITER. out_valid rises after E_ITER.
- Fixed latency is ITER cycles from accept to out_valid. For default widths, ITER = 4.
- Minimum back-to-back period is ITER+2 cycles: accept, ITER × CALC, DONE with out_ready=1, then IDLE.
- out_ready held low stretches DONE indefinitely. No combinational path from out_ready to in_ready.
- in_ready and out_valid are registered-state decodes with no combinational dependence on in_valid.

## Configuration
- Macro BOOTH_MULT_EARLY_TERM_EN.
- Defined: at each CALC edge, if the remaining window b[BX-1 : 2k-1] is all-0 or all-1, the block goes to DONE without adding.
  - Remaining digits are all zero in that case, so the product is unchanged.
  - Latency becomes variable, from 1 to ITER cycles.
  - Example: B=0 gives latency 1; B=1 gives latency 2.
- Undefined: fixed latency ITER. The window check is absent from the netlist.

## Test plan
- Signed path, defaults: in_signed=1, A=15, B=9 → out_valid 4 cycles after accept, P=12'h087. out_ready=1 → IDLE, in_ready=1 the next cycle.
- Signed extremes: A=6'b100000, B=6'b100000 (−32·−32) → P=12'h400. A=B=6'b111111 (−1·−1) → P=12'h001.
- Unsigned mode: in_signed=0, A=B=63 → P=12'hF81. A=63, B=1 → P=12'h03F. Latency 4.
- Backpressure: complete A=15, B=9 with out_ready=0 for 5 cycles.
  - P stays 12'h087, out_valid stays 1, in_ready stays 0.
  - A new in_valid with A=2, B=2 is not accepted until one cycle after out_ready=1.
- Reset mid-op: accept A=15, B=9; assert rst for 1 cycle after E2.
  - Next cycle: out_valid=0, P=0, busy=0, in_ready=1.
  - out_valid must never rise for the aborted operation.
- Random sweep, 1000 ops, random in_signed, in_valid and out_ready gaps → every P matches the reference product for its mode.
  - With BOOTH_MULT_EARLY_TERM_EN: signed B=0 gives latency 1, B=1 gives latency 2, B=6'b011111 gives latency 4.

Source files
------------

// File: rtl/booth_mult_r4_hs.sv
// booth_mult_r4_hs: iterative radix-4 Booth multiplier with valid/ready
// handshakes on both sides. It consumes one Booth digit per cycle and holds
// the product until the consumer accepts it.
//
// Optional feature macro: BOOTH_MULT_EARLY_TERM_EN. When it is defined, the
// block finishes early once the remaining multiplier window is all-0 or all-1.
//
// Parameters:
//   A_WIDTH   multiplicand width (>= 2)
//   B_WIDTH   multiplier width (>= 2, odd values allowed)
//   P_WIDTH   product width, must equal A_WIDTH + B_WIDTH
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   A, B and in_signed are valid
//   in_ready   operands can be accepted (IDLE and not in reset)
//   in_signed  1 = two's-complement operands, 0 = unsigned
//   A, B       multiplicand and multiplier
//   out_valid  P holds a completed product
//   out_ready  consumer accepts P
//   P          product
//   busy       high in CALC or DONE
module booth_mult_r4_hs #(
    parameter int unsigned A_WIDTH = 6,
    parameter int unsigned B_WIDTH = 6,
    parameter int unsigned P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] P,
    output logic               busy
);

    localparam int unsigned ITER  = (B_WIDTH + 2) / 2;
    localparam int unsigned BX    = 2 * ITER;
    localparam int unsigned ACC_W = P_WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;   // multiplicand pre-scaled by 4^k
    logic [BX:0]        mult_q, mult_d;     // multiplier window, bit 0 is b[2k-1]
    logic [CNT_W-1:0]   k_q, k_d;

    logic [ACC_W-1:0]   a_ext;
    logic [BX:0]        b_ext;
    logic [ACC_W-1:0]   addend;
    logic               win_flat;

    // Operand extension; b[-1] = 0 sits below the multiplier
    assign a_ext = {{(ACC_W-A_WIDTH){in_signed & A[A_WIDTH-1]}}, A};
    assign b_ext = {{(BX-B_WIDTH){in_signed & B[B_WIDTH-1]}}, B, 1'b0};

    // Booth digit recoding of the current triplet
    always_comb begin
        addend = '0;
        case (mult_q[2:0])
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = mcand_q << 1;
            3'b100:         addend = ACC_W'(0) - (mcand_q << 1);
            3'b101, 3'b110: addend = ACC_W'(0) - mcand_q;
            default:        addend = '0;
        endcase
    end

    // The window is shifted arithmetically, so the fill bits replicate
    // b[BX-1] and a flat register means a flat remaining window.
`ifdef BOOTH_MULT_EARLY_TERM_EN
    assign win_flat = (mult_q == '0) || (mult_q == '1);
`else
    assign win_flat = 1'b0;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    mcand_d = a_ext;
                    mult_d  = b_ext;
                    k_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (win_flat) begin
                    state_d = S_DONE;
                end else begin
                    acc_d   = acc_q + addend;
                    mcand_d = mcand_q << 2;
                    mult_d  = {{2{mult_q[BX]}}, mult_q[BX:2]};
                    k_d     = k_q + CNT_W'(1);
                    if (k_q == CNT_W'(ITER - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign P         = acc_q[P_WIDTH-1:0];

endmodule

// File: tb/tb_booth_mult_r4_hs.sv
// Directed testbench for booth_mult_r4_hs at default widths (6x6 -> 12).
module tb_booth_mult_r4_hs;

`ifdef BOOTH_MULT_EARLY_TERM_EN
    localparam int DEF_LAT = 0;   // 0 = latency only range-checked
    localparam int LAT_B0  = 1;
    localparam int LAT_B1  = 2;
`else
    localparam int DEF_LAT = 4;
    localparam int LAT_B0  = 4;
    localparam int LAT_B1  = 4;
`endif
    localparam int LAT_B31 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] p;
    logic        busy;

    int checks = 0;
    int errors = 0;

    booth_mult_r4_hs #(
        .A_WIDTH(6),
        .B_WIDTH(6),
        .P_WIDTH(12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // One complete transaction with immediate consumption of the result
    task automatic do_op(input string tag, input logic [5:0] av, input logic [5:0] bv,
                         input logic sv, input logic [11:0] exp_p, input int exp_lat);
        int lat;
        check({tag, "/in_ready"}, 32'(in_ready), 32'(1));
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        in_signed = sv;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        a         = 6'($urandom);
        b         = 6'($urandom);
        in_signed = 1'($urandom);
        check({tag, "/busy"}, 32'(busy), 32'(1));
        check({tag, "/in_ready_calc"}, 32'(in_ready), 32'(0));
        wait_out(lat);
        check({tag, "/out_valid"}, 32'(out_valid), 32'(1));
        check({tag, "/P"}, 32'(p), 32'(exp_p));
        if (exp_lat != 0) check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        else check({tag, "/latency_range"}, 32'(lat >= 1 && lat <= 4), 32'(1));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/out_valid_drop"}, 32'(out_valid), 32'(0));
        check({tag, "/in_ready_back"}, 32'(in_ready), 32'(1));
        check({tag, "/busy_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int  lat;
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_signed = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst/in_ready", 32'(in_ready), 32'(0));
        check("rst/out_valid", 32'(out_valid), 32'(0));
        check("rst/P", 32'(p), 32'(0));
        check("rst/busy", 32'(busy), 32'(0));
        rst = 1'b0;
        #1;
        check("rst/in_ready_after", 32'(in_ready), 32'(1));

        // Signed and unsigned directed products
        do_op("s_15x9",    6'd15,      6'd9,       1'b1, 12'h087, DEF_LAT);
        do_op("s_m32xm32", 6'b100000,  6'b100000,  1'b1, 12'h400, DEF_LAT);
        do_op("s_m1xm1",   6'b111111,  6'b111111,  1'b1, 12'h001, DEF_LAT);
        do_op("u_63x63",   6'd63,      6'd63,      1'b0, 12'hF81, DEF_LAT);
        do_op("u_63x1",    6'd63,      6'd1,       1'b0, 12'h03F, DEF_LAT);
        do_op("s_m32x31",  6'b100000,  6'b011111,  1'b1, 12'hC20, DEF_LAT);
        do_op("s_31xm32",  6'b011111,  6'b100000,  1'b1, 12'hC20, DEF_LAT);
        do_op("u_32x63",   6'b100000,  6'b111111,  1'b0, 12'h7E0, DEF_LAT);
        do_op("s_m7x5",    6'b111001,  6'b000101,  1'b1, 12'hFDD, DEF_LAT);
        do_op("s_m1x1",    6'b111111,  6'b000001,  1'b1, 12'hFFF, DEF_LAT);
        do_op("s_5x0",     6'd5,       6'd0,       1'b1, 12'h000, LAT_B0);
        do_op("s_5x1",     6'd5,       6'd1,       1'b1, 12'h005, LAT_B1);
        do_op("s_3x31",    6'd3,       6'b011111,  1'b1, 12'h05D, LAT_B31);

        // Backpressure: result held while out_ready is low
        in_valid  = 1'b1;
        a         = 6'd15;
        b         = 6'd9;
        in_signed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("bp/out_valid", 32'(out_valid), 32'(1));
        check("bp/P", 32'(p), 32'(12'h087));
        in_valid  = 1'b1;
        a         = 6'd2;
        b         = 6'd2;
        in_signed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp/P_hold", 32'(p), 32'(12'h087));
            check("bp/out_valid_hold", 32'(out_valid), 32'(1));
            check("bp/in_ready_hold", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp/out_valid_drop", 32'(out_valid), 32'(0));
        check("bp/in_ready_idle", 32'(in_ready), 32'(1));
        check("bp/not_accepted_yet", 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp/accepted", 32'(busy), 32'(1));
        wait_out(lat);
        check("bp/P2", 32'(p), 32'(12'h004));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp/idle2", 32'(in_ready), 32'(1));

        // Reset in the middle of CALC discards the operation
        in_valid  = 1'b1;
        a         = 6'd15;
        b         = 6'd9;
        in_signed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmid/in_ready_in_rst", 32'(in_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmid/out_valid", 32'(out_valid), 32'(0));
        check("rmid/P", 32'(p), 32'(0));
        check("rmid/busy", 32'(busy), 32'(0));
        check("rmid/in_ready", 32'(in_ready), 32'(1));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("rmid/no_out_valid", 32'(seen), 32'(0));
        do_op("post_rst_u_63x1", 6'd63, 6'd1, 1'b0, 12'h03F, DEF_LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
